sdfa_spike_packer: RTL
======================

SDFA_SPIKE_PACKER -- requirements
Module: sdfa_spike_packer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: CLK (rising edge) and RESET.
REQ-002 Ports SHALL be exactly as follows:
- CLK  in  1  clock
- RESET  in  1  synchronous active-high reset
- CFG_VALID  in  1  load CFG_KEEP and CFG_NUM_WORDS
- CFG_KEEP  in  3  word width code: 111=8, 011=4, 001=2, any other=1 bit
- CFG_NUM_WORDS  in  8  words per image minus 1
- OUT_SPIKE_VALID  in  1  upstream spike qualifier
- OUT_SPIKE  in  1  upstream serial spike
- BACK_DONE  in  1  upstream end-of-image pulse
- NEXT_READY  in  1  downstream block can accept an image
- START  out  1  first-word strobe to the downstream block
- EN  out  1  DATA_OUT qualifier
- DATA_OUT  out  8  packed spike word, zero-extended
- IMG_READY  out  1  a full image is buffered
- ERR_OVF  out  1  sticky overflow/overrun flag

Function
REQ-003 Config SHALL load on CFG_VALID only in state IDLE with buffer empty; otherwise CFG_VALID is ignored.
REQ-004 Packing SHALL be LSB-first: the k-th valid spike of a word goes to bit k; unused upper bits SHALL be 0.
REQ-005 When the bit count reaches the word width W, the word SHALL be written to a 256x8 buffer in the same cycle as the last spike; bit count returns to 0.
REQ-006 On BACK_DONE with a partial word pending, the partial word SHALL be written zero-padded; if BACK_DONE and OUT_SPIKE_VALID coincide, that spike is included first.
REQ-007 If fewer than CFG_NUM_WORDS+1 words exist at BACK_DONE, zero words SHALL be appended, one per cycle, until the count is reached.
REQ-008 Spikes arriving after CFG_NUM_WORDS+1 words are written SHALL be dropped and SHALL set ERR_OVF.
REQ-009 The FSM SHALL have states IDLE, FILL, PAD, HOLD and STREAM:
- IDLE -> FILL on first OUT_SPIKE_VALID.
- FILL -> PAD on BACK_DONE if short; otherwise FILL -> HOLD.
- PAD -> HOLD when the count is reached.
- HOLD -> STREAM when NEXT_READY=1.
- STREAM -> IDLE after the last word is issued.
REQ-010 IMG_READY SHALL be 1 exactly in HOLD.
REQ-011 STREAM SHALL issue words on consecutive cycles, first word in the cycle after the HOLD->STREAM transition:
- EN=1 for CFG_NUM_WORDS+1 cycles.
- START=1 only with word 0.
- DATA_OUT = word i in cycle i.
- No stall once started.
REQ-012 OUT_SPIKE_VALID in HOLD or STREAM (image overrun) SHALL be dropped and SHALL set ERR_OVF.
REQ-013 BACK_DONE in IDLE SHALL be ignored.
REQ-014 Buffer read and write addresses SHALL be 8 bit; word index 255 is the last legal index, with no wrap within an image.
REQ-015 Outside STREAM, START=0, EN=0 and DATA_OUT=0.

Reset
REQ-016 On RESET=1 at a clock edge:
- State SHALL go to IDLE; bit and word counters SHALL be 0.
- ERR_OVF SHALL be 0; START, EN, DATA_OUT and IMG_READY SHALL be 0.
- CFG_KEEP SHALL be 111 and CFG_NUM_WORDS SHALL be 31.
- Buffer contents are don't-care.
REQ-017 Reset asserted mid-FILL or mid-STREAM SHALL abort the image, with no further EN after the reset edge.

Configuration
REQ-018 Macro SDFA_PACKER_SPIKE_COUNT_EN defined: the block SHALL add output SPIKE_COUNT (16 bit, saturating).
- It counts OUT_SPIKE=1 accepted spikes of the current image.
- It clears on RESET and on the STREAM->IDLE transition.
REQ-019 Macro undefined: SPIKE_COUNT and its counter SHALL be absent; all other behaviour is identical.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- KEEP=111, NUM_WORDS=31, 256 valid spikes alternating 1,0, BACK_DONE, NEXT_READY=1 -> 32 words 0x55 on consecutive EN cycles, START with the first only, IMG_READY for 1 cycle.
- KEEP=011, NUM_WORDS=63, 256 spikes all 1 -> 64 words 0x0F, ERR_OVF=0.
- KEEP=111, NUM_WORDS=3, 10 spikes all 1 then BACK_DONE -> words 0xFF, 0x03, 0x00, 0x00.
- KEEP=001, NUM_WORDS=1, 6 spikes all 1 -> words 0x03, 0x03, ERR_OVF=1 after the 5th spike.
- Image buffered, NEXT_READY=0 for 20 cycles, then a spike arrives -> IMG_READY held for 20 cycles, ERR_OVF=1, no EN; NEXT_READY=1 -> the original image streams unchanged.
- RESET pulse at stream word 5 -> EN=0 from the next cycle; config reads back as defaults (the next image streams 32 words).

Source files
------------

// File: rtl/sdfa_spike_packer.sv
// sdfa_spike_packer
// Packs a serial spike stream LSB-first into words of 1, 2, 4 or 8 bits,
// buffers one image of up to 256 words, then streams it to the downstream
// block on consecutive cycles once that block is ready.
//
// Ports
//   CLK              clock (rising edge)
//   RESET            synchronous active-high reset
//   CFG_VALID        load CFG_KEEP / CFG_NUM_WORDS (IDLE with empty buffer only)
//   CFG_KEEP[2:0]    word width code: 111=8, 011=4, 001=2, other=1 bit
//   CFG_NUM_WORDS    words per image minus 1
//   OUT_SPIKE_VALID  upstream spike qualifier
//   OUT_SPIKE        upstream serial spike
//   BACK_DONE        upstream end-of-image pulse
//   NEXT_READY       downstream block can accept an image
//   START            first-word strobe (with word 0 only)
//   EN               DATA_OUT qualifier
//   DATA_OUT[7:0]    packed spike word, zero-extended
//   IMG_READY        a full image is buffered (HOLD)
//   ERR_OVF          sticky overflow/overrun flag
//   SPIKE_COUNT      (optional) saturating count of accepted 1-spikes
//
// Build option: define SDFA_PACKER_SPIKE_COUNT_EN to add SPIKE_COUNT.

module sdfa_spike_packer (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CFG_VALID,
    input  logic [2:0] CFG_KEEP,
    input  logic [7:0] CFG_NUM_WORDS,
    input  logic       OUT_SPIKE_VALID,
    input  logic       OUT_SPIKE,
    input  logic       BACK_DONE,
    input  logic       NEXT_READY,
    output logic       START,
    output logic       EN,
    output logic [7:0] DATA_OUT,
    output logic       IMG_READY,
    output logic       ERR_OVF
`ifdef SDFA_PACKER_SPIKE_COUNT_EN
    ,
    output logic [15:0] SPIKE_COUNT
`endif
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 256;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned CNT_W  = 9;
    localparam int unsigned BIT_W  = 4;
`ifdef SDFA_PACKER_SPIKE_COUNT_EN
    localparam int unsigned SCNT_W = 16;
`endif

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        PAD,
        HOLD,
        STREAM
    } state_t;

    state_t state_q, state_d;

    logic [2:0]        cfg_keep_q;
    logic [ADDR_W-1:0] cfg_nw_q;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [ADDR_W-1:0] rd_idx_q, rd_idx_d;

    logic              start_d, en_d, img_ready_d, ovf_d;
    logic [DATA_W-1:0] dout_d;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [BIT_W-1:0]  word_w;
    logic [CNT_W-1:0]  total;
    logic              full;
    logic              accept;
    logic [DATA_W-1:0] packed_word;
    logic [BIT_W-1:0]  bits_after;
    logic [CNT_W-1:0]  words_after;
    logic              cfg_load;

    // Word width decode from the configured keep code
    always_comb begin
        word_w = BIT_W'(1);
        case (cfg_keep_q)
            3'b111:  word_w = BIT_W'(8);
            3'b011:  word_w = BIT_W'(4);
            3'b001:  word_w = BIT_W'(2);
            default: word_w = BIT_W'(1);
        endcase
    end

    assign total    = CNT_W'(cfg_nw_q) + CNT_W'(1);
    assign full     = (word_cnt_q == total);
    assign cfg_load = CFG_VALID && (state_q == IDLE) &&
                      (word_cnt_q == '0) && (bit_cnt_q == '0);

    // FSM state register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, packing, buffer write and stream output decode
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        word_cnt_d  = word_cnt_q;
        shift_d     = shift_q;
        rd_idx_d    = rd_idx_q;
        start_d     = 1'b0;
        en_d        = 1'b0;
        dout_d      = '0;
        ovf_d       = ERR_OVF;
        wr_en       = 1'b0;
        wr_addr     = word_cnt_q[ADDR_W-1:0];
        wr_data     = '0;
        accept      = 1'b0;
        packed_word = shift_q;
        bits_after  = bit_cnt_q;
        words_after = word_cnt_q;

        // Spikes land only while an image is open and not yet full
        accept = OUT_SPIKE_VALID &&
                 ((state_q == IDLE) || ((state_q == FILL) && !full));
        if (OUT_SPIKE_VALID && !accept) begin
            ovf_d = 1'b1;
        end
        if (accept) begin
            packed_word = shift_q | (DATA_W'(OUT_SPIKE) << bit_cnt_q);
            bits_after  = bit_cnt_q + BIT_W'(1);
        end

        case (state_q)
            IDLE, FILL: begin
                // Complete word, or zero-padded partial word at end of image
                if ((accept && (bits_after == word_w)) ||
                    ((state_q == FILL) && BACK_DONE && (bits_after != '0))) begin
                    wr_en       = 1'b1;
                    wr_data     = packed_word;
                    shift_d     = '0;
                    bit_cnt_d   = '0;
                    words_after = word_cnt_q + CNT_W'(1);
                end else begin
                    shift_d   = packed_word;
                    bit_cnt_d = bits_after;
                end
                word_cnt_d = words_after;
                if (state_q == IDLE) begin
                    if (accept) begin
                        state_d = FILL;
                    end
                end else if (BACK_DONE) begin
                    state_d = (words_after < total) ? PAD : HOLD;
                end
            end
            PAD: begin
                wr_en      = 1'b1;
                wr_data    = '0;
                word_cnt_d = word_cnt_q + CNT_W'(1);
                if ((word_cnt_q + CNT_W'(1)) == total) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (NEXT_READY) begin
                    state_d  = STREAM;
                    rd_idx_d = '0;
                    en_d     = 1'b1;
                    start_d  = 1'b1;
                    dout_d   = mem[0];
                end
            end
            STREAM: begin
                // rd_idx_q is the word currently on DATA_OUT
                if (rd_idx_q == cfg_nw_q) begin
                    state_d    = IDLE;
                    word_cnt_d = '0;
                    bit_cnt_d  = '0;
                    shift_d    = '0;
                    rd_idx_d   = '0;
                end else begin
                    rd_idx_d = ADDR_W'(rd_idx_q + ADDR_W'(1));
                    en_d     = 1'b1;
                    dout_d   = mem[ADDR_W'(rd_idx_q + ADDR_W'(1))];
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        img_ready_d = (state_d == HOLD);
    end

    // Datapath and registered outputs
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cfg_keep_q <= 3'b111;
            cfg_nw_q   <= ADDR_W'(31);
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            shift_q    <= '0;
            rd_idx_q   <= '0;
            START      <= 1'b0;
            EN         <= 1'b0;
            DATA_OUT   <= '0;
            IMG_READY  <= 1'b0;
            ERR_OVF    <= 1'b0;
        end else begin
            if (cfg_load) begin
                cfg_keep_q <= CFG_KEEP;
                cfg_nw_q   <= CFG_NUM_WORDS;
            end
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
            shift_q    <= shift_d;
            rd_idx_q   <= rd_idx_d;
            START      <= start_d;
            EN         <= en_d;
            DATA_OUT   <= dout_d;
            IMG_READY  <= img_ready_d;
            ERR_OVF    <= ovf_d;
        end
    end

    // Image buffer; contents need no reset
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

`ifdef SDFA_PACKER_SPIKE_COUNT_EN
    // Saturating count of accepted 1-spikes in the current image
    always_ff @(posedge CLK) begin
        if (RESET) begin
            SPIKE_COUNT <= '0;
        end else if ((state_q == STREAM) && (state_d == IDLE)) begin
            SPIKE_COUNT <= '0;
        end else if (accept && OUT_SPIKE && (SPIKE_COUNT != {SCNT_W{1'b1}})) begin
            SPIKE_COUNT <= SPIKE_COUNT + SCNT_W'(1);
        end
    end
`endif

endmodule
